// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit 7-segment display.
// Each digit slot is a BLANK gap followed by a SHOW period. The displayed value is updated only at frame boundaries.
module seg_scan_ctrl #(
   parameter int unsigned SHOW_CYCLES  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] disp_in_i,
   input  logic        disp_we_i,
   input  logic [7:0]  en_mask_i,
   input  logic        lz_blank_i,
   output logic [3:0]  data_o,
   output logic [7:0]  sel_o,
   output logic        frame_done_o
);

   localparam int unsigned MaxCycles = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYCLES - 1);
   // With a gap of 0 or 1 cycles, BLANK lasts exactly one cycle.
   // A gap of 0 only occurs in the BLANK state entered at reset.
   localparam logic [CntW-1:0] BlankLast = (BLANK_CYCLES > 1) ? CntW'(BLANK_CYCLES - 1) : '0;
   localparam bit NoGap = (BLANK_CYCLES == 0);

   typedef enum logic [0:0] {StBlank, StShow} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [31:0]     pending_q, pending_d;
   logic [31:0]     shadow_q, shadow_d;
   logic [3:0]      data_q, data_d;
   logic [7:0]      sel_q, sel_d;
   logic            frame_done_q, frame_done_d;

   logic [4:0]      nib_lsb;
   logic [31:0]     upper_mask;
   logic            lz_hit;
   logic            frame_wrap;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      idx_d      = idx_q;
      shadow_d   = shadow_q;
      frame_wrap = 1'b0;
      pending_d  = disp_we_i ? disp_in_i : pending_q;

      case (state_q)
         StBlank: begin
            if (cnt_q == BlankLast) begin
               state_d = StShow;
               cnt_d   = '0;
            end
         end
         StShow: begin
            if (cnt_q == ShowLast) begin
               cnt_d   = '0;
               idx_d   = idx_q + 3'd1;
               state_d = NoGap ? StShow : StBlank;
               // Latch the pending value as it was before this edge.
               // A write arriving on this same cycle is shown one frame later.
               if (idx_q == 3'd7) begin
                  frame_wrap = 1'b1;
                  shadow_d   = pending_q;
               end
            end
         end
         default: begin
            state_d = StBlank;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from next-state values.
   // This keeps sel/data aligned with the slot the FSM is entering.
   always_comb begin
      nib_lsb    = {idx_d, 2'b00};
      upper_mask = 32'hFFFF_FFFF << nib_lsb;
      lz_hit     = lz_blank_i && (idx_d != 3'd0) && ((shadow_d & upper_mask) == 32'd0);
      data_d     = shadow_d[nib_lsb +: 4];
      sel_d      = 8'hFF;
      if ((state_d == StShow) && en_mask_i[idx_d] && !lz_hit) begin
         sel_d = ~(8'b1 << idx_d);
      end
      frame_done_d = frame_wrap;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StBlank;
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         pending_q    <= 32'd0;
         shadow_q     <= 32'd0;
         data_q       <= 4'd0;
         sel_q        <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         shadow_q     <= shadow_d;
         data_q       <= data_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign data_o       = data_q;
   assign sel_o        = sel_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl (SHOW=4, BLANK=1).
// Expected outputs come from a slot-position model computed from an edge count.
module tb_seg_scan_ctrl;

   localparam int SHOW  = 4;
   localparam int BLANK = 1;
   localparam int SLOT  = SHOW + BLANK;
   localparam int FRAME = 8 * SLOT;

   logic        clk;
   logic        rst;
   logic [31:0] disp_in;
   logic        disp_we;
   logic [7:0]  en_mask;
   logic        lz_blank;
   logic [3:0]  data;
   logic [7:0]  sel;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state.
   // k is the number of non-reset edges since the last reset edge.
   int          k;
   int          m_idx;
   bit          m_show;
   logic [31:0] m_pending;
   logic [31:0] m_shadow;
   logic [7:0]  exp_sel;
   logic [3:0]  exp_data;
   logic        exp_fd;

   seg_scan_ctrl #(
      .SHOW_CYCLES (SHOW),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .disp_in_i   (disp_in),
      .disp_we_i   (disp_we),
      .en_mask_i   (en_mask),
      .lz_blank_i  (lz_blank),
      .data_o      (data),
      .sel_o       (sel),
      .frame_done_o(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock.
   // Update the model from the inputs seen at the edge, then settle at the falling edge.
   task automatic tick();
      bit lz;
      @(posedge clk);
      cyc++;
      if (rst) begin
         k = 0; m_idx = 0; m_show = 1'b0;
         m_pending = 32'd0; m_shadow = 32'd0;
         exp_sel = 8'hFF; exp_data = 4'd0; exp_fd = 1'b0;
      end else begin
         k++;
         if (k % FRAME == 0) m_shadow = m_pending;
         if (disp_we) m_pending = disp_in;
         m_idx    = (k / SLOT) % 8;
         m_show   = (k % SLOT) >= BLANK;
         exp_data = m_shadow[4*m_idx +: 4];
         lz       = lz_blank && (m_idx != 0) && ((m_shadow >> (4*m_idx)) == 32'd0);
         exp_sel  = (m_show && en_mask[m_idx] && !lz) ? ~(8'h01 << m_idx) : 8'hFF;
         exp_fd   = (k % FRAME == 0);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; disp_we = 1'b0; disp_in = 32'd0; en_mask = 8'hFF; lz_blank = 1'b0;
      repeat (3) tick();
      checks++;
      if (sel !== 8'hFF) begin errors++; $display("FAIL reset_sel got=%h want=ff", sel); end
      checks++;
      if (data !== 4'd0) begin errors++; $display("FAIL reset_data got=%h want=0", data); end
      checks++;
      if (frame_done !== 1'b0) begin
         errors++; $display("FAIL reset_fd got=%b want=0", frame_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] ref_v = 32'h1234_5678;
      disp_in = ref_v; disp_we = 1'b1;
      tick();
      disp_we = 1'b0; disp_in = $urandom();
      for (int n = 0; n < 79; n++) begin
         tick();
         checks++;
         if (sel !== exp_sel || data !== exp_data || frame_done !== exp_fd) begin
            errors++;
            $display("FAIL basic k=%0d got sel=%h data=%h fd=%b want sel=%h data=%h fd=%b",
                     k, sel, data, frame_done, exp_sel, exp_data, exp_fd);
         end
         if (k < FRAME) begin
            checks++;
            if (data !== 4'd0) begin
               errors++; $display("FAIL basic_frame1 k=%0d data=%h want=0", k, data);
            end
         end else if (k > FRAME && k < 2*FRAME && m_show) begin
            checks++;
            if (data !== ref_v[4*m_idx +: 4] || sel !== ~(8'h01 << m_idx)) begin
               errors++;
               $display("FAIL basic_frame2 k=%0d got data=%h sel=%h want data=%h sel=%h",
                        k, data, sel, ref_v[4*m_idx +: 4], ~(8'h01 << m_idx));
            end
         end
      end
   endtask

   task automatic test_frame_timing();
      int   last_fd = -1;
      logic prev_fd = 1'b0;
      for (int n = 0; n < 3*FRAME; n++) begin
         tick();
         checks++;
         if (frame_done !== exp_fd || sel !== exp_sel) begin
            errors++;
            $display("FAIL timing k=%0d got fd=%b sel=%h want fd=%b sel=%h",
                     k, frame_done, sel, exp_fd, exp_sel);
         end
         if (frame_done === 1'b1) begin
            checks++;
            if (prev_fd === 1'b1) begin
               errors++; $display("FAIL fd_width k=%0d got=2+ cycles want=1", k);
            end
            if (last_fd >= 0) begin
               checks++;
               if (cyc - last_fd != FRAME) begin
                  errors++;
                  $display("FAIL fd_period got=%0d want=%0d", cyc - last_fd, FRAME);
               end
            end
            last_fd = cyc;
         end
         prev_fd = frame_done;
      end
   endtask

   task automatic test_write_policy();
      logic [31:0] old_v;
      for (int n = 0; n < FRAME + 2 && (k % FRAME) != 0; n++) tick();
      checks++;
      if ((k % FRAME) != 0) begin errors++; $display("FAIL wp_align k=%0d want frame start", k); end
      old_v = m_shadow;
      for (int n = 0; n < FRAME; n++) begin
         if (n == 15) begin disp_in = 32'hAAAA_AAAA; disp_we = 1'b1; end
         else if (n == 20) begin disp_in = 32'hBBBB_BBBB; disp_we = 1'b1; end
         else disp_we = 1'b0;
         checks++;
         if (data !== old_v[4*m_idx +: 4]) begin
            errors++;
            $display("FAIL wp_current k=%0d data=%h want=%h", k, data, old_v[4*m_idx +: 4]);
         end
         tick();
      end
      disp_we = 1'b0;
      for (int n = 0; n < 3*FRAME; n++) begin
         checks++;
         if (data !== ((n < 2*FRAME) ? 4'hB : 4'hC) || sel !== exp_sel) begin
            errors++;
            $display("FAIL wp_next k=%0d got data=%h sel=%h want data=%h sel=%h",
                     k, data, sel, (n < 2*FRAME) ? 4'hB : 4'hC, exp_sel);
         end
         // Write on the boundary cycle: shown one frame late.
         if (n == FRAME - 1) begin disp_in = 32'hCCCC_CCCC; disp_we = 1'b1; end
         else disp_we = 1'b0;
         tick();
      end
      disp_we = 1'b0;
   endtask

   task automatic test_lz();
      logic [31:0] vals [2] = '{32'h0000_00A0, 32'h0000_0000};
      lz_blank = 1'b1;
      for (int v = 0; v < 2; v++) begin
         for (int n = 0; n < FRAME + 2 && (k % FRAME) != 0; n++) tick();
         disp_in = vals[v]; disp_we = 1'b1;
         tick();
         disp_we = 1'b0;
         for (int n = 0; n < FRAME + 2 && (k % FRAME) != 0; n++) tick();
         for (int n = 0; n < FRAME; n++) begin
            logic [7:0] want_sel;
            logic [3:0] want_data;
            want_data = (v == 0 && m_idx == 1) ? 4'hA : 4'h0;
            if (!m_show) want_sel = 8'hFF;
            else if (m_idx == 0) want_sel = 8'hFE;
            else if (m_idx == 1 && v == 0) want_sel = 8'hFD;
            else want_sel = 8'hFF;
            checks++;
            if (sel !== want_sel || data !== want_data || sel !== exp_sel) begin
               errors++;
               $display("FAIL lz v=%0d k=%0d got sel=%h data=%h want sel=%h data=%h",
                        v, k, sel, data, want_sel, want_data);
            end
            tick();
         end
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_mask();
      int last_fd = -1;
      en_mask = 8'h0F;
      disp_in = $urandom(); disp_we = 1'b1;
      tick();
      disp_we = 1'b0;
      for (int n = 0; n < 2*FRAME; n++) begin
         tick();
         checks++;
         if (sel !== exp_sel || data !== exp_data || frame_done !== exp_fd) begin
            errors++;
            $display("FAIL mask k=%0d got sel=%h data=%h fd=%b want sel=%h data=%h fd=%b",
                     k, sel, data, frame_done, exp_sel, exp_data, exp_fd);
         end
         if (m_idx >= 4) begin
            checks++;
            if (sel !== 8'hFF) begin
               errors++; $display("FAIL mask_off k=%0d digit=%0d sel=%h want=ff", k, m_idx, sel);
            end
         end
         if (frame_done === 1'b1) begin
            if (last_fd >= 0) begin
               checks++;
               if (cyc - last_fd != FRAME) begin
                  errors++;
                  $display("FAIL mask_period got=%0d want=%0d", cyc - last_fd, FRAME);
               end
            end
            last_fd = cyc;
         end
      end
      en_mask = 8'hFF;
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         disp_we = ($urandom_range(0, 5) == 0);
         disp_in = $urandom() >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) en_mask = 8'($urandom());
         if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom());
         tick();
         checks++;
         if (sel !== exp_sel || data !== exp_data || frame_done !== exp_fd) begin
            errors++;
            $display("FAIL random k=%0d got sel=%h data=%h fd=%b want sel=%h data=%h fd=%b",
                     k, sel, data, frame_done, exp_sel, exp_data, exp_fd);
         end
         checks++;
         if ($countones(~sel) > 1 || (!m_show && sel !== 8'hFF)) begin
            errors++;
            $display("FAIL sel_onehot k=%0d sel=%h show=%b want <=1 low, ff in blank",
                     k, sel, m_show);
         end
      end
      disp_we = 1'b0; en_mask = 8'hFF; lz_blank = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      disp_in = 32'hDEAD_BEEF; disp_we = 1'b1;
      tick();
      disp_we = 1'b0;
      for (int n = 0; n < FRAME + 2 && !found; n++) begin
         if (m_idx == 5 && m_show) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rst_mid_find got=none want=digit5 SHOW"); end
      rst = 1'b1;
      tick();
      checks++;
      if (sel !== 8'hFF || data !== 4'd0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got sel=%h data=%h fd=%b want sel=ff data=0 fd=0",
                  sel, data, frame_done);
      end
      rst = 1'b0;
      for (int n = 0; n < 2*FRAME; n++) begin
         tick();
         checks++;
         if (sel !== exp_sel || data !== 4'd0 || frame_done !== exp_fd) begin
            errors++;
            $display("FAIL rst_restart k=%0d got sel=%h data=%h fd=%b want sel=%h data=0 fd=%b",
                     k, sel, data, frame_done, exp_sel, exp_fd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame_timing();
      test_write_policy();
      test_lz();
      test_mask();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
